// File: rtl/hdlc_tx_frame_ctrl.sv
// Multi-channel HDLC TX frame controller: EMIF-loaded byte buffers, flag window, valid/ready stream.
// Define HDLC_TX_STAT_EN to enable the per-channel 16-bit frame counters on frame_cnt.
module hdlc_tx_frame_ctrl #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned FLAG_LEN = 84
) (
  input  logic                clk_100m,
  input  logic                rst_n,
  input  logic                emif_wen,
  input  logic [23:0]         emif_addr,
  input  logic [15:0]         emif_data,
  input  logic [NCH-1:0]      tx_rdy,
  output logic [NCH-1:0]      tx_valid,
  output logic [8*NCH-1:0]    tx_data,
  output logic [NCH-1:0]      tx_last,
  output logic [NCH-1:0]      trastart_flag,
  output logic [NCH-1:0]      busy,
  output logic [NCH-1:0]      done,
  output logic [NCH-1:0]      start_err,
  output logic [16*NCH-1:0]   frame_cnt
);

  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PtrOne = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [15:0]     FlagLast = 16'(FLAG_LEN);

  typedef enum logic [1:0] {StIdle, StFlag, StFetch, StValid} state_e;

  logic              data_wr, start_wr;
  logic [CH_W-1:0]   wr_ch, st_ch;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   st_len;
  logic              unused_emif;

  assign data_wr  = emif_wen & ~emif_addr[23];
  assign start_wr = emif_wen & emif_addr[23];
  assign wr_ch    = emif_addr[ADDR_W+CH_W-1:ADDR_W];
  assign wr_addr  = emif_addr[ADDR_W-1:0];
  assign st_ch    = emif_addr[CH_W-1:0];
  assign st_len   = emif_data[ADDR_W:0];
  assign unused_emif = ^{emif_addr[22:ADDR_W+CH_W], emif_data[15:ADDR_W+1]};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_e          state_q, state_d;
    logic [ADDR_W:0] ptr_q, ptr_d, len_q, len_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [7:0]      rd_q;
    logic            done_q, err_q;
    logic [15:0]     fcnt;
    logic [7:0]      mem_q [Depth];
    logic            st_hit, st_ok, is_last, fin;
    logic            valid_c, last_c, flag_c, busy_c;

    assign st_hit  = start_wr && (st_ch == CH_W'(c));
    assign st_ok   = st_hit && (state_q == StIdle) && (st_len != '0) && (st_len <= MaxLen);
    assign is_last = (ptr_q == len_q - PtrOne);
    assign fin     = (state_q == StValid) && tx_rdy[c] && is_last;

    // Buffer is not reset; writes are only taken while the channel is idle.
    always_ff @(posedge clk_100m) begin
      if (data_wr && (wr_ch == CH_W'(c)) && (state_q == StIdle)) begin
        mem_q[wr_addr] <= emif_data[7:0];
      end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
        ptr_q   <= '0;
        len_q   <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        len_q   <= len_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        StIdle: begin
          if (st_ok) begin
            state_d = StFlag;
            ptr_d   = '0;
            len_d   = st_len;
            cnt_d   = 16'd1;
          end
        end
        StFlag: begin
          if (cnt_q >= FlagLast) state_d = StFetch;
          else                   cnt_d   = cnt_q + 16'd1;
        end
        StFetch: state_d = StValid;
        StValid: begin
          if (tx_rdy[c]) begin
            if (is_last) begin
              state_d = StIdle;
            end else begin
              state_d = StFetch;
              ptr_d   = ptr_q + PtrOne;
            end
          end
        end
      endcase
    end

    always_comb begin
      valid_c = (state_q == StValid);
      last_c  = valid_c && is_last;
      flag_c  = (state_q == StFlag);
      busy_c  = (state_q != StIdle);
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
        rd_q   <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        if (state_q == StFetch) rd_q <= mem_q[ptr_q[ADDR_W-1:0]];
        done_q <= fin;
        err_q  <= st_hit && !st_ok;
      end
    end

`ifdef HDLC_TX_STAT_EN
    logic [15:0] fcnt_q;
    always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
        fcnt_q <= '0;
      end else if (st_ok && emif_data[15]) begin
        fcnt_q <= '0;
      end else if (fin) begin
        fcnt_q <= fcnt_q + 16'd1;
      end
    end
    assign fcnt = fcnt_q;
`else
    assign fcnt = '0;
`endif

    assign tx_valid[c]          = valid_c;
    assign tx_last[c]           = last_c;
    assign trastart_flag[c]     = flag_c;
    assign busy[c]              = busy_c;
    assign done[c]              = done_q;
    assign start_err[c]         = err_q;
    assign tx_data[8*c +: 8]    = rd_q;
    assign frame_cnt[16*c +: 16] = fcnt;
  end

endmodule

// File: tb/tb_hdlc_tx_frame_ctrl.sv
// Directed self-checking bench for hdlc_tx_frame_ctrl (NCH=2, ADDR_W=9, FLAG_LEN=84).
module tb_hdlc_tx_frame_ctrl;
  localparam int NCH = 2;
  localparam int ADDR_W = 9;
  localparam int FLAG_LEN = 84;
`ifdef HDLC_TX_STAT_EN
  localparam bit Stat = 1'b1;
`else
  localparam bit Stat = 1'b0;
`endif

  logic        clk_100m = 1'b0;
  logic        rst_n = 1'b0;
  logic        emif_wen = 1'b0;
  logic [23:0] emif_addr = '0;
  logic [15:0] emif_data = '0;
  logic [1:0]  tx_rdy = '0;
  logic [1:0]  tx_valid, tx_last, trastart_flag, busy, done, start_err;
  logic [15:0] tx_data;
  logic [31:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  logic [8:0] got0[$];
  logic [8:0] got1[$];
  int done_cnt[2] = '{0, 0};

  hdlc_tx_frame_ctrl #(.NCH(NCH), .ADDR_W(ADDR_W), .FLAG_LEN(FLAG_LEN)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .emif_wen(emif_wen), .emif_addr(emif_addr),
    .emif_data(emif_data), .tx_rdy(tx_rdy), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .trastart_flag(trastart_flag), .busy(busy), .done(done),
    .start_err(start_err), .frame_cnt(frame_cnt)
  );

  always #5 clk_100m = ~clk_100m;

  // Record every accepted byte as {last, data} and every done pulse.
  always @(negedge clk_100m) begin
    if (tx_valid[0] && tx_rdy[0]) got0.push_back({tx_last[0], tx_data[7:0]});
    if (tx_valid[1] && tx_rdy[1]) got1.push_back({tx_last[1], tx_data[15:8]});
    if (done[0]) done_cnt[0]++;
    if (done[1]) done_cnt[1]++;
  end

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic emif_wr(input logic [23:0] a, input logic [15:0] d);
    emif_wen = 1'b1; emif_addr = a; emif_data = d;
    tick();
    emif_wen = 1'b0;
  endtask

  function automatic logic [23:0] daddr(input int ch, input int a);
    return 24'((ch << ADDR_W) | a);
  endfunction

  function automatic logic [23:0] saddr(input int ch);
    return 24'h800000 | 24'(ch);
  endfunction

  task automatic wait_done(input int c, input int budget, output bit ok);
    int n0;
    n0 = done_cnt[c];
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_cnt[c] != n0) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(input int c, input int budget, output bit ok);
    ok = tx_valid[c];
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = tx_valid[c];
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({tx_valid, tx_last, trastart_flag, busy, done, start_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0",
               {tx_valid, tx_last, trastart_flag, busy, done, start_err});
    end
    checks++;
    if (tx_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0", tx_data); end
    checks++;
    if (frame_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_fcnt: got %h want 0", frame_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    int n;
    logic [8:0] exp;
    emif_wr(daddr(0, 0), 16'h0011);
    emif_wr(daddr(0, 1), 16'h0022);
    emif_wr(daddr(0, 2), 16'h0033);
    tx_rdy[0] = 1'b1;
    emif_wr(saddr(0), 16'd3);
    checks++;
    if ({busy[0], trastart_flag[0]} !== 2'b11) begin
      errors++; $display("FAIL single_start: busy/flag %b want 11", {busy[0], trastart_flag[0]});
    end
    n = 0;
    while (trastart_flag[0] && n < 200) begin n++; tick(); end
    checks++;
    if (n != FLAG_LEN) begin errors++; $display("FAIL flag_len: got %0d want %0d", n, FLAG_LEN); end
    checks++;
    if ({tx_valid[0], busy[0]} !== 2'b01) begin
      errors++; $display("FAIL fetch_cycle: valid/busy %b want 01", {tx_valid[0], busy[0]});
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      exp = {1'(i == 2), 8'(17 * (i + 1))};
      checks++;
      if ({tx_valid[0], tx_last[0], tx_data[7:0]} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL single_byte%0d: got %h want %h", i,
                 {tx_valid[0], tx_last[0], tx_data[7:0]}, {1'b1, exp});
      end
      tick();
      if (i < 2) begin
        checks++;
        if (tx_valid[0] !== 1'b0) begin errors++; $display("FAIL gap%0d: valid %b want 0", i, tx_valid[0]); end
        tick();
      end
    end
    checks++;
    if ({done[0], busy[0]} !== 2'b10) begin
      errors++; $display("FAIL single_done: done/busy %b want 10", {done[0], busy[0]});
    end
    tick();
    checks++;
    if (done[0] !== 1'b0) begin errors++; $display("FAIL done_pulse: done %b want 0", done[0]); end
    tx_rdy[0] = 1'b0;
  endtask

  task automatic test_backpressure();
    int base;
    bit ok;
    for (int i = 0; i < 4; i++) emif_wr(daddr(0, i), 16'(8'hA0 + i));
    tx_rdy[0] = 1'b0;
    base = got0.size();
    emif_wr(saddr(0), 16'd4);
    wait_valid(0, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_valid: got timeout want tx_valid"); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({tx_valid[0], tx_data[7:0]} !== 9'h1A0) begin
        errors++; $display("FAIL bp_hold%0d: got %h want 1a0", i, {tx_valid[0], tx_data[7:0]});
      end
      tick();
    end
    tx_rdy[0] = 1'b1;
    wait_done(0, 100, ok);
    checks++;
    if (!ok || got0.size() - base != 4) begin
      errors++; $display("FAIL bp_count: got %0d bytes (done=%0b) want 4", got0.size() - base, ok);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got0[base+i] !== {1'(i == 3), 8'(8'hA0 + i)}) begin
          errors++; $display("FAIL bp_byte%0d: got %h want %h", i, got0[base+i],
                             {1'(i == 3), 8'(8'hA0 + i)});
        end
      end
    end
    tx_rdy[0] = 1'b0;
  endtask

  task automatic test_concurrent();
    int b0, b1, d0, d1;
    emif_wr(daddr(0, 0), 16'h0001);
    emif_wr(daddr(0, 1), 16'h0002);
    for (int i = 0; i < 5; i++) emif_wr(daddr(1, i), 16'(8'h51 + i));
    tx_rdy = 2'b11;
    b0 = got0.size(); b1 = got1.size();
    d0 = done_cnt[0]; d1 = done_cnt[1];
    emif_wr(saddr(0), 16'd2);
    emif_wr(saddr(1), 16'd5);
    for (int i = 0; i < 300 && (done_cnt[0] == d0 || done_cnt[1] == d1); i++) tick();
    tick();
    checks++;
    if (done_cnt[0] - d0 != 1 || done_cnt[1] - d1 != 1) begin
      errors++; $display("FAIL conc_done: got %0d/%0d want 1/1", done_cnt[0] - d0, done_cnt[1] - d1);
    end
    checks++;
    if (got0.size() - b0 != 2 || got1.size() - b1 != 5) begin
      errors++; $display("FAIL conc_count: got %0d/%0d want 2/5", got0.size() - b0, got1.size() - b1);
    end else begin
      checks++;
      if ({got0[b0], got0[b0+1]} !== {9'h001, 9'h102}) begin
        errors++; $display("FAIL conc_ch0: got %h %h want 001 102", got0[b0], got0[b0+1]);
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got1[b1+i] !== {1'(i == 4), 8'(8'h51 + i)}) begin
          errors++; $display("FAIL conc_ch1_%0d: got %h want %h", i, got1[b1+i],
                             {1'(i == 4), 8'(8'h51 + i)});
        end
      end
    end
    tx_rdy = 2'b00;
  endtask

  task automatic test_rejects();
    int b1;
    bit ok;
    emif_wr(saddr(0), 16'd0);
    checks++;
    if ({start_err, busy} !== 4'b0100) begin
      errors++; $display("FAIL rej_len0: err/busy %b want 0100", {start_err, busy});
    end
    tick();
    checks++;
    if (start_err !== 2'b00) begin errors++; $display("FAIL rej_pulse: err %b want 00", start_err); end
    emif_wr(saddr(0), 16'd513);
    checks++;
    if ({start_err, busy} !== 4'b0100) begin
      errors++; $display("FAIL rej_len513: err/busy %b want 0100", {start_err, busy});
    end
    tx_rdy[1] = 1'b0;
    b1 = got1.size();
    emif_wr(saddr(1), 16'd2);
    checks++;
    if ({start_err, busy} !== 4'b0010) begin
      errors++; $display("FAIL rej_ok_start: err/busy %b want 0010", {start_err, busy});
    end
    emif_wr(saddr(1), 16'd1);
    checks++;
    if ({start_err, busy} !== 4'b1010) begin
      errors++; $display("FAIL rej_busy: err/busy %b want 1010", {start_err, busy});
    end
    emif_wr(daddr(1, 0), 16'h00EE);
    tx_rdy[1] = 1'b1;
    wait_done(1, 200, ok);
    checks++;
    if (!ok || got1.size() - b1 != 2) begin
      errors++; $display("FAIL rej_stream_cnt: got %0d (done=%0b) want 2", got1.size() - b1, ok);
    end else begin
      checks++;
      if ({got1[b1], got1[b1+1]} !== {9'h051, 9'h152}) begin
        errors++; $display("FAIL rej_stream: got %h %h want 051 152", got1[b1], got1[b1+1]);
      end
    end
    tx_rdy[1] = 1'b0;
  endtask

  task automatic test_full_depth();
    int base, bad;
    bit ok;
    for (int a = 0; a < 512; a++) emif_wr(daddr(0, a), 16'(a & 255));
    base = got0.size();
    tx_rdy[0] = 1'b1;
    emif_wr(saddr(0), 16'd512);
    checks++;
    if ({start_err[0], busy[0]} !== 2'b01) begin
      errors++; $display("FAIL full_start: err/busy %b want 01", {start_err[0], busy[0]});
    end
    wait_done(0, 1500, ok);
    checks++;
    if (!ok || got0.size() - base != 512) begin
      errors++; $display("FAIL full_count: got %0d (done=%0b) want 512", got0.size() - base, ok);
    end else begin
      bad = 0;
      for (int i = 0; i < 512; i++) if (got0[base+i] !== {1'(i == 511), 8'(i)}) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL full_data: got %0d bad bytes want 0", bad); end
    end
    tx_rdy[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int b1, d1;
    bit ok;
    for (int i = 0; i < 3; i++) emif_wr(daddr(1, i), 16'(8'h61 + i));
    tx_rdy[1] = 1'b0;
    emif_wr(saddr(1), 16'd3);
    wait_valid(1, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_valid: got timeout want tx_valid"); end
    d1 = done_cnt[1];
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_valid, tx_last, trastart_flag, busy, done, start_err} !== 12'h000 ||
        tx_data !== 16'h0 || frame_cnt !== 32'h0) begin
      errors++; $display("FAIL mid_reset: ctrl %b data %h fcnt %h want 0",
                         {tx_valid, tx_last, trastart_flag, busy, done, start_err}, tx_data, frame_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (done_cnt[1] != d1 || busy !== 2'b00) begin
      errors++; $display("FAIL mid_nodone: done+%0d busy %b want 0 00", done_cnt[1] - d1, busy);
    end
    emif_wr(daddr(1, 0), 16'h0071);
    emif_wr(daddr(1, 1), 16'h0072);
    b1 = got1.size();
    tx_rdy[1] = 1'b1;
    emif_wr(saddr(1), 16'd2);
    wait_done(1, 200, ok);
    checks++;
    if (!ok || got1.size() - b1 != 2) begin
      errors++; $display("FAIL mid_after_cnt: got %0d (done=%0b) want 2", got1.size() - b1, ok);
    end else begin
      checks++;
      if ({got1[b1], got1[b1+1]} !== {9'h071, 9'h172}) begin
        errors++; $display("FAIL mid_after: got %h %h want 071 172", got1[b1], got1[b1+1]);
      end
    end
    tx_rdy[1] = 1'b0;
  endtask

  task automatic test_stats();
    bit ok;
    emif_wr(daddr(0, 0), 16'h005A);
    tx_rdy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      emif_wr(saddr(0), 16'd1);
      wait_done(0, 200, ok);
    end
    checks++;
    if (frame_cnt[15:0] !== (Stat ? 16'd3 : 16'd0)) begin
      errors++; $display("FAIL stat_three: got %0d want %0d", frame_cnt[15:0], Stat ? 3 : 0);
    end
    checks++;
    if (frame_cnt[31:16] !== (Stat ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL stat_ch1: got %0d want %0d", frame_cnt[31:16], Stat ? 1 : 0);
    end
    emif_wr(saddr(0), 16'h8001);
    checks++;
    if ({start_err[0], busy[0], frame_cnt[15:0]} !== {2'b01, 16'd0}) begin
      errors++; $display("FAIL stat_clear: err/busy %b cnt %0d want 01 0",
                         {start_err[0], busy[0]}, frame_cnt[15:0]);
    end
    wait_done(0, 200, ok);
    checks++;
    if (!ok || frame_cnt[15:0] !== (Stat ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL stat_after: got %0d (done=%0b) want %0d", frame_cnt[15:0], ok, Stat ? 1 : 0);
    end
    tx_rdy[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_concurrent();
    test_rejects();
    test_full_depth();
    test_reset_mid();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_frame_ctrl.md
# hdlc_tx_frame_ctrl

Multi-channel HDLC transmit-frame controller in the `clk_100m` domain. The DSP writes frame bytes over EMIF into a per-channel buffer, then writes a length word to start transmission. For each channel the block raises a flag-window strobe for the serializer's opening 7E flags, then streams the buffered bytes over a valid/ready handshake. Each downstream HDLC bit serializer owns its own CDC.

## Interface
Parameters:
- `NCH`, 2: number of independent TX channels (1..8).
- `ADDR_W`, 9: per-channel buffer address width; depth is 2^ADDR_W bytes (ADDR_W ≤ 12).
- `FLAG_LEN`, 84: length of the `trastart_flag` window in clk_100m cycles (≥ 2, < 2^16).
- `CH_W`, derived: max(1, clog2(NCH)).

Ports (clock and reset first):
- `clk_100m`  in  1  system/EMIF clock.
- `rst_n`  in  1  Reset: asynchronous, active-low. Clock is clk_100m.
- `emif_wen`  in  1  single-cycle EMIF write strobe.
- `emif_addr`  in  24  EMIF word address.
- `emif_data`  in  16  EMIF write data.
- `tx_rdy`  in  NCH  serializer accepts byte, per channel.
- `tx_valid`  out  NCH  byte present on tx_data slice.
- `tx_data`  out  8*NCH  byte for channel c on [8c+7:8c].
- `tx_last`  out  NCH  qualifies final byte of the frame.
- `trastart_flag`  out  NCH  flag-window strobe.
- `busy`  out  NCH  channel frame in progress.
- `done`  out  NCH  one-cycle pulse at frame end.
- `start_err`  out  NCH  one-cycle pulse when a start is rejected.
- `frame_cnt`  out  16*NCH  frames sent per channel (see Configuration).

## Operation
- Address decode applies only when `emif_wen` = 1.
- Data write: `emif_addr[23]` = 0. Channel = `emif_addr[ADDR_W+CH_W-1:ADDR_W]`. Byte address = `emif_addr[ADDR_W-1:0]`. `emif_data[7:0]` is stored.
  - Channel index ≥ NCH: write dropped.
  - Write to a busy channel: dropped.
- Start write: `emif_addr[23]` = 1, `emif_addr[CH_W-1:0]` = channel, `emif_data[ADDR_W:0]` = LEN.
  - Accepted when the channel is IDLE and 1 ≤ LEN ≤ 2^ADDR_W.
  - Otherwise `start_err[c]` pulses and state is unchanged.
- Per-channel FSM, one instance per channel:
  - IDLE: wait for an accepted start. Go to FLAG, with byte pointer = 0 and flag counter = 1.
  - FLAG: hold `trastart_flag` = 1 while the counter ≤ FLAG_LEN, then go to FETCH.
  - FETCH: issue a RAM read at the pointer (registered-output RAM, 1-cycle latency). Go to VALID.
  - VALID: drive `tx_valid` = 1 with stable `tx_data`/`tx_last`.
    - On `tx_rdy`, if pointer = LEN-1: go to IDLE and pulse `done`.
    - On `tx_rdy` otherwise: increment pointer and go to FETCH.
- `tx_last` = 1 exactly while the pointer = LEN-1 in VALID.
- `busy` = 1 in FLAG, FETCH and VALID.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- Arithmetic:
  - Pointer is ADDR_W+1 bits wide; it never wraps because LEN ≤ 2^ADDR_W.
  - Flag counter is 16 bits.
- `tx_rdy` while `tx_valid` = 0: ignored.
- Reset mid-frame: every channel returns to IDLE at once, with no `done` pulse. Buffer contents are undefined after reset.
- Reset values: all outputs 0, including `tx_data` and `frame_cnt`.

## Timing
- Start write in cycle T:
  - `busy` and `trastart_flag` are 1 from T+1 through T+FLAG_LEN.
  - FETCH is at T+FLAG_LEN+1.
  - First `tx_valid` is at T+FLAG_LEN+2.
- Handshake accepted in cycle A, not last byte: `tx_valid` = 0 at A+1 and next byte valid at A+2. Peak rate is 1 byte per 2 cycles.
- Handshake on the last byte in cycle A: `done` = 1 and `busy` = 0 at A+1. A new start is accepted from A+1.
- Data write in cycle W is readable by a FETCH at W+1 or later.

## Configuration
- `HDLC_TX_STAT_EN` defined:
  - Each channel has a 16-bit `frame_cnt` that increments on `done` and wraps 0xFFFF→0.
  - A start write with `emif_data[15]` = 1 also clears that channel's counter, in the same cycle as the accept.
- Undefined: `frame_cnt` is tied to 0, and bit 15 of the start word is ignored.

## Test plan
- Single frame: ch0 bytes 0x11,0x22,0x33, start LEN=3, `tx_rdy` held 1 → `trastart_flag[0]` high for 84 cycles, then bytes 0x11,0x22,0x33 on alternate cycles, `tx_last` on 0x33, `done[0]` 1 cycle later.
- Backpressure: `tx_rdy` low for 10 cycles during VALID → `tx_data` and `tx_valid` held stable; no byte lost or duplicated.
- Concurrent channels: ch0 LEN=2 and ch1 LEN=5 started in adjacent cycles → independent streams, each in correct order, each with a separate `done`.
- Rejects: start LEN=0, start LEN=513 (ADDR_W=9), and start on a busy channel → `start_err` pulses, busy state unchanged; a data write during busy does not alter the stream.
- Full depth: LEN=512 with pattern addr[7:0] → all 512 bytes stream correctly and the pointer does not wrap.
- Reset mid-VALID on ch1 → all outputs 0 immediately; a following frame runs normally. With `HDLC_TX_STAT_EN`, `frame_cnt` = 3 after three frames and 0 after a clear-start.
